serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Multi-cycle magnitude comparator: the parametrised successor of the 6-bit bitwise equality comparator.
//   - Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
//   - Reports equal / less / greater, not just equality.
//   - Stops early at the first differing chunk.
//   - Supports unsigned or two's-complement operands.
//   - Sits on the datapath as a start/done co-unit beside the ALU.
// PARAMETERS
//   WIDTH   16  operand width in bits; WIDTH >= 1
//   CHUNK   4   bits compared per cycle; must divide WIDTH; N = WIDTH/CHUNK chunks
//   SIGNED  0   0 = unsigned compare, 1 = two's-complement compare
// PORTS
//   clk     in   1      single clock, rising edge
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      request compare; sampled only in IDLE
//   a       in   WIDTH  operand A; latched on the accepted start
//   b       in   WIDTH  operand B; latched on the accepted start
//   busy    out  1      high while state != IDLE
//   done    out  1      one-cycle pulse: result valid
//   igual   out  1      A == B
//   menor   out  1      A < B
//   maior   out  1      A > B
// BEHAVIOUR
//   Reset: async and immediate. State = IDLE; busy = done = igual = menor = maior = 0; operand regs and index cleared.
//   FSM states: IDLE, COMPARE, DONE.
//   IDLE -> COMPARE
//     - On a clk edge with start = 1: latch a and b, set idx = N-1.
//     - In the same edge, clear igual, menor and maior to 0.
//   COMPARE, each edge: examine chunk idx, bits [idx*CHUNK +: CHUNK] of A and B.
//     - Chunks differ: maior = (chunkA > chunkB), menor = !maior; go to DONE.
//     - Chunks equal and idx == 0: igual = 1; go to DONE.
//     - Chunks equal and idx > 0: idx <= idx-1; stay in COMPARE.
//   DONE: done = 1 for exactly this one cycle; go to IDLE on the next edge.
//   Signed mode (SIGNED = 1):
//     - Invert the sign bit, bit WIDTH-1, of both operands before chunk N-1 is compared.
//     - Lower chunks are compared unsigned.
//   Latency: k cycles from the accepted start edge to the edge that enters DONE.
//     - k = number of chunks examined, 1 <= k <= N.
//     - done is visible in the cycle after that edge.
//     - Minimum start-to-start spacing is k+2 cycles.
//   Results:
//     - When valid, exactly one of igual / menor / maior is 1.
//     - They are registered outputs, held after done until the next accepted start.
//   start while busy (COMPARE or DONE): ignored. Operands are not re-latched and the result is unaffected.
//   a / b changing after the accepted start have no effect (latched copies are used).
//   reset mid-COMPARE or in DONE: aborts the operation; no done pulse; all outputs 0.
//   CHUNK == WIDTH: single-cycle compare; k = 1 always.
//   idx width: clog2(N), minimum 1 bit. idx never underflows.
// TESTING  (WIDTH=16, CHUNK=4 unless noted)
//   1 a=b=16'hA5A5, start -> done after 4 cycles; igual=1, menor=0, maior=0.
//   2 unsigned a=16'h8000, b=16'h7FFF -> done after 1 cycle; maior=1.
//   3 a=16'h1234, b=16'h1235 -> done after 4 cycles; menor=1.
//     Results held 5 further cycles without a new start.
//   4 SIGNED=1: a=16'h8000 (-32768), b=16'h0001 -> done after 1 cycle; menor=1.
//     Same case with a=16'hFFFF, b=16'hFFFE -> maior=1 after 4 cycles.
//   5 start pulsed again during COMPARE with a=b=0 -> ignored; original result reported.
//     reset asserted at cycle 2 of a compare -> all outputs 0 immediately, no done.
//     A fresh start afterwards completes normally.
//   6 WIDTH=6, CHUNK=1: 500 random (a,b) pairs plus all-equal vectors 000110 and 111111.
//     - Flags match a reference (==, <, >) model.
//     - Cycle count equals the index of the first differing bit from the MSB, plus 1 (6 when equal).

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the MSB down.
// It stops at the first differing chunk. Unsigned or two's-complement compare.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CHUNK  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             igual,
  output logic             menor,
  output logic             maior
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SignFlip = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              igual_q, igual_d, menor_q, menor_d, maior_q, maior_d;
  logic [CHUNK-1:0]  chunk_a, chunk_b;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    igual_d = igual_q;
    menor_d = menor_q;
    maior_d = maior_q;
    chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a ^ SignFlip;
          b_d     = b ^ SignFlip;
          idx_d   = IdxTop;
          igual_d = 1'b0;
          menor_d = 1'b0;
          maior_d = 1'b0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (chunk_a != chunk_b) begin
          maior_d = (chunk_a > chunk_b);
          menor_d = !(chunk_a > chunk_b);
          state_d = StDone;
        end else if (idx_q == '0) begin
          igual_d = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      igual_q <= 1'b0;
      menor_q <= 1'b0;
      maior_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      igual_q <= igual_d;
      menor_q <= menor_d;
      maior_q <= maior_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign igual = igual_q;
  assign menor = menor_q;
  assign maior = maior_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: four configurations, directed vectors,
// multi-cycle corner sequences and random pairs against an arithmetic reference.
module tb_serial_magnitude_comparator;

  logic        clk;
  logic        reset;
  logic [3:0]  start_r;
  logic [15:0] a_r [4];
  logic [15:0] b_r [4];
  logic [3:0]  busy_w, done_w, igual_w, menor_w, maior_w;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          u;
    logic [15:0] a;
    logic [15:0] b;
    int          k;
    logic [2:0]  f;   // {igual, menor, maior}
  } vec_t;

  vec_t vecs[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .reset(reset), .start(start_r[0]), .a(a_r[0]), .b(b_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .igual(igual_w[0]), .menor(menor_w[0]),
    .maior(maior_w[0])
  );

  serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .reset(reset), .start(start_r[1]), .a(a_r[1]), .b(b_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .igual(igual_w[1]), .menor(menor_w[1]),
    .maior(maior_w[1])
  );

  serial_magnitude_comparator #(.WIDTH(6), .CHUNK(1), .SIGNED(1'b0)) u_u6 (
    .clk(clk), .reset(reset), .start(start_r[2]), .a(a_r[2][5:0]), .b(b_r[2][5:0]),
    .busy(busy_w[2]), .done(done_w[2]), .igual(igual_w[2]), .menor(menor_w[2]),
    .maior(maior_w[2])
  );

  serial_magnitude_comparator #(.WIDTH(8), .CHUNK(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .reset(reset), .start(start_r[3]), .a(a_r[3][7:0]), .b(b_r[3][7:0]),
    .busy(busy_w[3]), .done(done_w[3]), .igual(igual_w[3]), .menor(menor_w[3]),
    .maior(maior_w[3])
  );

  function automatic int unsigned uw(input int u);
    case (u)
      2:       return 6;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int unsigned uc(input int u);
    case (u)
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit usg(input int u);
    return (u == 1) || (u == 3);
  endfunction

  function automatic logic [2:0] ref_flags(input int u, input int unsigned a, input int unsigned b);
    longint sa, sb, full;
    full = longint'(1) << uw(u);
    sa = longint'(a);
    sb = longint'(b);
    if (usg(u)) begin
      if (sa >= full / 2) sa = sa - full;
      if (sb >= full / 2) sb = sb - full;
    end
    return {sa == sb, sa < sb, sa > sb};
  endfunction

  // Number of chunks examined: position of the first differing chunk from the MSB, plus 1.
  function automatic int ref_k(input int u, input int unsigned a, input int unsigned b);
    int unsigned n, c, cmask, sh;
    c = uc(u);
    n = uw(u) / c;
    cmask = (c >= 32) ? 32'hFFFF_FFFF : ((32'd1 << c) - 1);
    for (int i = 0; i < int'(n); i++) begin
      sh = (n - 1 - i) * c;
      if (((a >> sh) & cmask) != ((b >> sh) & cmask)) return i + 1;
    end
    return int'(n);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_cmp(input int u, input logic [15:0] a, input logic [15:0] b,
                         input int exp_k, input logic [2:0] exp_f, input bit poke,
                         input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    start_r[u] = 1'b1;
    a_r[u] = a;
    b_r[u] = b;
    @(posedge clk);
    #1;
    start_r[u] = 1'b0;
    a_r[u] = 16'($urandom);
    b_r[u] = 16'($urandom);
    check({nm, "_busy"}, busy_w[u], 1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 1) begin
        start_r[u] = 1'b1;
        a_r[u] = '0;
        b_r[u] = '0;
      end else if (poke && cyc == 2) begin
        start_r[u] = 1'b0;
      end
      seen = done_w[u];
    end
    start_r[u] = 1'b0;
    check({nm, "_latency"}, seen ? cyc : -1, exp_k);
    check({nm, "_flags"}, {igual_w[u], menor_w[u], maior_w[u]}, exp_f);
    @(posedge clk);
    #1;
    check({nm, "_after"}, {busy_w[u], done_w[u], igual_w[u], menor_w[u], maior_w[u]},
          {2'b00, exp_f});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mask, ra, rb, cnt;
    bit any_done;
    reset = 1'b1;
    start_r = '0;
    for (int i = 0; i < 4; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end
    #12;
    check("reset_state", {busy_w, done_w, igual_w, menor_w, maior_w}, 0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0]  = '{0, 16'hA5A5, 16'hA5A5, 4, 3'b100};
    vecs[1]  = '{0, 16'h8000, 16'h7FFF, 1, 3'b001};
    vecs[2]  = '{0, 16'h1234, 16'h1235, 4, 3'b010};
    vecs[3]  = '{1, 16'h8000, 16'h0001, 1, 3'b010};
    vecs[4]  = '{1, 16'hFFFF, 16'hFFFE, 4, 3'b001};
    vecs[5]  = '{0, 16'h0100, 16'h0200, 2, 3'b010};
    vecs[6]  = '{0, 16'h0001, 16'h0000, 4, 3'b001};
    vecs[7]  = '{1, 16'h7FFF, 16'h8000, 1, 3'b001};
    vecs[8]  = '{2, 16'h0006, 16'h0006, 6, 3'b100};
    vecs[9]  = '{2, 16'h003F, 16'h003F, 6, 3'b100};
    vecs[10] = '{2, 16'h0020, 16'h0010, 1, 3'b001};
    vecs[11] = '{3, 16'h0080, 16'h007F, 1, 3'b010};
    vecs[12] = '{3, 16'h0055, 16'h0055, 1, 3'b100};
    for (int i = 0; i < 13; i++) begin
      run_cmp(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].f, 1'b0,
              $sformatf("vec%0d", i));
    end

    // Result held without a new start.
    run_cmp(0, 16'h1234, 16'h1235, 4, 3'b010, 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_cycle", {done_w[0], igual_w[0], menor_w[0], maior_w[0]}, 4'b0010);
    end

    // Start pulsed with a=b=0 during COMPARE must be ignored.
    run_cmp(0, 16'h1234, 16'h1235, 4, 3'b010, 1'b1, "busy_start");

    // Reset in the middle of a compare.
    @(negedge clk);
    start_r[0] = 1'b1;
    a_r[0] = 16'h1234;
    b_r[0] = 16'h1235;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid", {busy_w[0], done_w[0], igual_w[0], menor_w[0], maior_w[0]}, 0);
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      any_done |= done_w[0] | busy_w[0];
    end
    check("rst_mid_no_done", any_done, 0);

    // Reset during DONE clears the flags at once.
    @(negedge clk);
    start_r[0] = 1'b1;
    a_r[0] = 16'h8000;
    b_r[0] = 16'h7FFF;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    @(posedge clk);
    #1;
    check("rst_done_pre", {done_w[0], maior_w[0]}, 2'b11);
    reset = 1'b1;
    #1;
    check("rst_done", {busy_w[0], done_w[0], igual_w[0], menor_w[0], maior_w[0]}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_cmp(0, 16'hA5A5, 16'hA5A5, 4, 3'b100, 1'b0, "fresh");

    for (int u = 0; u < 4; u++) begin
      mask = (32'd1 << uw(u)) - 1;
      cnt = (u == 2) ? 500 : 60;
      for (int i = 0; i < int'(cnt); i++) begin
        ra = $urandom & mask;
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = $urandom & mask;
          default: rb = (ra ^ (32'd1 << $urandom_range(0, uw(u) - 1))) & mask;
        endcase
        run_cmp(u, 16'(ra), 16'(rb), ref_k(u, ra, rb), ref_flags(u, ra, rb), 1'b0,
                $sformatf("rnd_u%0d_%0h_%0h", u, ra, rb));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
